// File: rtl/fft_bit_reverse_stream.sv
// Streaming bit-reversal buffer: stores one frame in natural order, emits it in bit-reversed order.
// Define FFT_BITREV_PINGPONG_EN for two banks so one frame fills while the other drains.
module fft_bit_reverse_stream #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    output logic [BIT_WIDTH-1:0] send_msg,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic                 send_last
);
    localparam int IDX_W = (N_SAMPLES >= 2) ? $clog2(N_SAMPLES) : 1;
`ifdef FFT_BITREV_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam logic [1:0] FILLING  = 2'd0;
    localparam logic [1:0] FULL     = 2'd1;
    localparam logic [1:0] DRAINING = 2'd2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    if (N_SAMPLES < 2 || (N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_bad_n
        $error("fft_bit_reverse_stream: N_SAMPLES must be a power of two >= 2");
    end

    logic [IDX_W-1:0]     wr_idx_reg, wr_idx_next;
    logic [IDX_W-1:0]     rd_idx_reg, rd_idx_next;
    logic [IDX_W-1:0]     rev_idx;
    logic                 wb_reg, wb_next;
    logic                 rb_reg, rb_next;
    logic [1:0]           full_vec;
    logic [BIT_WIDTH-1:0] bank_rd [2];
    logic                 wr_fire, rd_fire;
    logic                 wr_last, rd_last;

    assign recv_rdy  = !full_vec[wb_reg] && !reset;
    assign send_val  = full_vec[rb_reg];
    assign send_msg  = send_val ? bank_rd[rb_reg] : '0;
    assign wr_last   = (wr_idx_reg == LAST_IDX);
    assign rd_last   = (rd_idx_reg == LAST_IDX);
    assign send_last = send_val && rd_last;
    assign wr_fire   = recv_val && recv_rdy;
    assign rd_fire   = send_val && send_rdy;

    // Read address is the mirrored drain counter.
    for (genvar gi = 0; gi < IDX_W; gi++) begin : g_rev
        assign rev_idx[gi] = rd_idx_reg[IDX_W-1-gi];
    end

    // Bank slots beyond NB are tied off so the pointer muxes stay uniform in both builds.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        if (gi < NB) begin : g_used
            localparam logic BANK_ID = (gi == 1);
            logic [1:0]           state_reg, state_next;
            logic [BIT_WIDTH-1:0] mem_reg [N_SAMPLES];
            logic                 wr_sel, rd_sel;

            assign wr_sel = wr_fire && (wb_reg == BANK_ID);
            assign rd_sel = rd_fire && (rb_reg == BANK_ID);

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    FILLING: begin
                        if (wr_sel && wr_last) begin
                            state_next = FULL;
                        end
                    end
                    FULL: begin
                        if (rd_sel) begin
                            state_next = rd_last ? FILLING : DRAINING;
                        end
                    end
                    DRAINING: begin
                        if (rd_sel && rd_last) begin
                            state_next = FILLING;
                        end
                    end
                    default: state_next = FILLING;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= FILLING;
                end else begin
                    state_reg <= state_next;
                end
            end

            // Contents are deliberately not reset; a cleared bank is never read.
            always_ff @(posedge clk) begin
                if (wr_sel) begin
                    mem_reg[wr_idx_reg] <= recv_msg;
                end
            end

            assign full_vec[gi] = (state_reg != FILLING);
            assign bank_rd[gi]  = mem_reg[rev_idx];
        end else begin : g_unused
            assign full_vec[gi] = 1'b0;
            assign bank_rd[gi]  = '0;
        end
    end

    always_comb begin
        wr_idx_next = wr_idx_reg;
        wb_next     = wb_reg;
        if (wr_fire) begin
            wr_idx_next = wr_idx_reg + IDX_W'(1);
            if (wr_last && NB == 2) begin
                wb_next = ~wb_reg;
            end
        end
    end

    always_comb begin
        rd_idx_next = rd_idx_reg;
        rb_next     = rb_reg;
        if (rd_fire) begin
            rd_idx_next = rd_idx_reg + IDX_W'(1);
            if (rd_last && NB == 2) begin
                rb_next = ~rb_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
            wb_reg     <= 1'b0;
            rb_reg     <= 1'b0;
        end else begin
            wr_idx_reg <= wr_idx_next;
            rd_idx_reg <= rd_idx_next;
            wb_reg     <= wb_next;
            rb_reg     <= rb_next;
        end
    end
endmodule

// File: tb/tb_fft_bit_reverse_stream.sv
// Randomized bench for fft_bit_reverse_stream with a frame-level queue model of the stream.
module tb_fft_bit_reverse_stream;
    localparam int BW    = 32;
    localparam int NS    = 8;
    localparam int NBITS = 3;
`ifdef FFT_BITREV_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] recv_msg;
    logic          recv_val;
    logic          recv_rdy;
    logic [BW-1:0] send_msg;
    logic          send_val;
    logic          send_rdy;
    logic          send_last;

    always #5 clk = ~clk;

    fft_bit_reverse_stream #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) dut (
        .clk(clk), .reset(reset),
        .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
        .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
        .send_last(send_last)
    );

    int checks_cnt = 0;
    int fail_cnt   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: samples of the frame being filled, then whole frames already reordered.
    logic [BW-1:0] part_q[$];
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] got_q[$];
    int pending = 0;
    int out_pos = 0;
    int cyc = 0;
    int last_in_cyc = 0;
    int first_out_cyc = -1;
    int rdy_low_cnt = 0;
    bit last_rf = 0;
    bit hold_valid = 0;
    logic [BW-1:0] hold_msg = '0;

    function automatic int rev(input int i);
        int r = 0;
        for (int k = 0; k < NBITS; k++) begin
            if (((i >> k) & 1) != 0) r = r | (1 << (NBITS - 1 - k));
        end
        return r;
    endfunction

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic rf, sf, rst_s, rdy_s, hold_now;
        logic [BW-1:0] smsg, rmsg;
        #1;
        check_eq("recv_rdy", recv_rdy, (!reset && pending < NB));
        check_eq("send_val", send_val, (pending > 0));
        if (pending > 0 && exp_q.size() > 0) check_eq("send_msg", send_msg, exp_q[0]);
        else check_eq("send_msg_idle", send_msg, 0);
        check_eq("send_last", send_last, (pending > 0 && out_pos == NS - 1));
        if (hold_valid) check_eq("hold_stable", send_msg, hold_msg);
        rf = recv_val && recv_rdy;
        sf = send_val && send_rdy;
        smsg = send_msg;
        rmsg = recv_msg;
        rst_s = reset;
        rdy_s = send_rdy;
        hold_now = send_val && !rdy_s && !rst_s;
        if (recv_val && !recv_rdy) rdy_low_cnt++;
        @(posedge clk);
        cyc++;
        last_rf = rf;
        hold_valid = hold_now;
        hold_msg = smsg;
        if (rst_s) begin
            part_q.delete();
            exp_q.delete();
            pending = 0;
            out_pos = 0;
        end else begin
            if (sf) begin
                got_q.push_back(smsg);
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (pending > 0) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    out_pos++;
                    if (out_pos == NS) begin
                        out_pos = 0;
                        pending--;
                    end
                end
            end
            if (rf) begin
                part_q.push_back(rmsg);
                last_in_cyc = cyc;
                if (part_q.size() == NS) begin
                    for (int i = 0; i < NS; i++) exp_q.push_back(part_q[rev(i)]);
                    pending++;
                    part_q.delete();
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [BW-1:0] v);
        int waited = 0;
        bit done = 0;
        recv_val = 1'b1;
        recv_msg = v;
        while (!done && waited < 200) begin
            tick();
            done = last_rf;
            waited++;
        end
        if (!done) check_eq("push_timeout", done, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int exp1[8];
        int exp3[16];
        int acc;
        int idx;
        int cycles;
        exp1 = '{0, 4, 2, 6, 1, 5, 3, 7};
        exp3 = '{0, 4, 2, 6, 1, 5, 3, 7, 8, 12, 10, 14, 9, 13, 11, 15};

        reset = 1'b1; recv_val = 1'b0; recv_msg = '0; send_rdy = 1'b0;
        @(negedge clk);
        idle(2);
        reset = 1'b0;
        #1;
        check_eq("rst_send_val", send_val, 0);
        check_eq("rst_send_msg", send_msg, 0);
        check_eq("rst_send_last", send_last, 0);
        check_eq("rst_recv_rdy", recv_rdy, 1);
        @(negedge clk);

        // Directed frame 0..7 with an always-ready consumer.
        send_rdy = 1'b1;
        got_q.delete();
        first_out_cyc = -1;
        for (int v = 0; v < NS; v++) push(v);
        recv_val = 1'b0;
        check_eq("lat_val", send_val, 1);
        idle(12);
        check_eq("t1_count", got_q.size(), NS);
        for (int i = 0; i < NS && i < got_q.size(); i++) check_eq("t1_order", got_q[i], exp1[i]);
        check_eq("t1_latency", first_out_cyc - last_in_cyc, 1);

        // Two back-to-back frames with continuous valid/ready.
        got_q.delete();
        rdy_low_cnt = 0;
        for (int v = 0; v < 2 * NS; v++) push(v);
        recv_val = 1'b0;
        check_eq("t3_rdy_low", rdy_low_cnt, (NB == 2) ? 0 : NS);
        idle(20);
        check_eq("t3_count", got_q.size(), 2 * NS);
        for (int i = 0; i < 2 * NS && i < got_q.size(); i++) check_eq("t3_order", got_q[i], exp3[i]);

        // Random gaps on both sides, 20 frames of random data.
        got_q.delete();
        idx = 0;
        cycles = 0;
        while (got_q.size() < 20 * NS && cycles < 6000) begin
            recv_val = (idx < 20 * NS) && ($urandom_range(3) != 0);
            recv_msg = $urandom;
            send_rdy = ($urandom_range(2) != 0);
            tick();
            if (last_rf) idx++;
            cycles++;
        end
        recv_val = 1'b0;
        check_eq("t2_count", got_q.size(), 20 * NS);

        // Stalled consumer: fill every bank, then release.
        send_rdy = 1'b1;
        idle(20);
        send_rdy = 1'b0;
        got_q.delete();
        acc = 0;
        recv_val = 1'b1;
        for (int c = 0; c < 3 * NS; c++) begin
            recv_msg = 200 + acc;
            tick();
            if (last_rf) acc++;
        end
        check_eq("t4_accepted", acc, NB * NS);
        check_eq("t4_rdy_blocked", recv_rdy, 0);
        send_rdy = 1'b1;
        while (acc < 3 * NS) begin
            push(200 + acc);
            acc++;
        end
        recv_val = 1'b0;
        idle(40);
        check_eq("t4_count", got_q.size(), 3 * NS);
        for (int i = 0; i < 3 * NS && i < got_q.size(); i++)
            check_eq("t4_order", got_q[i], 200 + (i / NS) * NS + rev(i % NS));
        check_eq("t4_empty", send_val, 0);

        // Reset mid-fill, then mid-drain, then a clean frame.
        for (int v = 0; v < 5; v++) push(30 + v);
        recv_val = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t5_fill_val", send_val, 0);
        check_eq("t5_fill_last", send_last, 0);
        send_rdy = 1'b0;
        for (int v = 0; v < NS; v++) push(50 + v);
        recv_val = 1'b0;
        send_rdy = 1'b1;
        got_q.delete();
        cycles = 0;
        while (got_q.size() < 3 && cycles < 20) begin
            tick();
            cycles++;
        end
        check_eq("t5_three_out", got_q.size(), 3);
        reset = 1'b1;
        send_rdy = 1'b0;
        tick();
        reset = 1'b0;
        check_eq("t5_drain_val", send_val, 0);
        check_eq("t5_drain_msg", send_msg, 0);
        got_q.delete();
        send_rdy = 1'b1;
        for (int v = 0; v < NS; v++) push(100 + v);
        recv_val = 1'b0;
        idle(12);
        check_eq("t5_count", got_q.size(), NS);
        for (int i = 0; i < NS && i < got_q.size(); i++) check_eq("t5_order", got_q[i], 100 + exp1[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end
endmodule
